// File: rtl/cmpgt_bist.sv
// cmpgt_bist: self-test wrapper around a gate-level 4-bit unsigned a > b
// comparator. An 8-bit maximal LFSR supplies {a, b}; the (optionally
// fault-injected) comparator output is compacted into a 16-bit SISR and
// a ones count. Handshake: a one-cycle-or-longer `start` seen in IDLE or
// DONE launches a run; `busy` is high for exactly NPAT cycles, then
// `done` rises and results hold until the next accepted `start`.
`timescale 1ns/1ps
module cmpgt_bist #(
  parameter int unsigned NPAT   = 255,
  parameter logic [7:0]  SEED   = 8'h01,
  parameter logic [15:0] GOLDEN = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  inject_sa,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] signature,
  output logic [7:0]  ones_count,
  output logic [3:0]  pat_a,
  output logic [3:0]  pat_b,
  output logic        cmp_o,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [7:0] LAST_CNT = 8'(NPAT - 1);

  state_e      state_q, state_d;
  logic [7:0]  lfsr_q, lfsr_d;
  logic [15:0] sig_q, sig_d;
  logic [7:0]  ones_q, ones_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        pass_q, pass_d;

  // Gate-level comparator: per-bit GT/LT/EQ, rippled MSB first.
  logic [3:0] cmp_a, cmp_b, gt;
  logic [3:1] lt, eq;
  logic [4:0] gt_chain;
  logic [4:1] eq_chain;
  logic       cmp_raw;

  assign cmp_a       = lfsr_q[7:4];
  assign cmp_b       = lfsr_q[3:0];
  assign gt_chain[4] = 1'b0;
  assign eq_chain[4] = 1'b1;

  for (genvar i = 3; i >= 0; i--) begin : g_bit
    assign gt[i]       = cmp_a[i] & ~cmp_b[i];
    assign gt_chain[i] = gt_chain[i+1] | (eq_chain[i+1] & gt[i]);
    if (i > 0) begin : g_eq
      assign lt[i]       = ~cmp_a[i] & cmp_b[i];
      assign eq[i]       = ~(gt[i] | lt[i]);
      assign eq_chain[i] = eq_chain[i+1] & eq[i];
    end
  end

  assign cmp_raw = gt_chain[0];

  // Stuck-at injection on the comparator output; code 11 behaves as none.
  always_comb begin
    cmp_o = cmp_raw;
    case (inject_sa)
      2'b01:   cmp_o = 1'b0;
      2'b10:   cmp_o = 1'b1;
      default: cmp_o = cmp_raw;
    endcase
  end

  // Next-state: load on accepted start, absorb one pattern per RUN cycle.
  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    sig_d   = sig_q;
    ones_d  = ones_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = done_q;
    pass_d  = pass_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_RUN;
          lfsr_d  = SEED;
          sig_d   = 16'h0000;
          ones_d  = 8'h00;
          cnt_d   = 8'h00;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          pass_d  = 1'b0;
        end
      end
      S_RUN: begin
        sig_d  = {sig_q[14:0], sig_q[15] ^ sig_q[13] ^ sig_q[12] ^ sig_q[10] ^ cmp_o};
        ones_d = ones_q + {7'b0, cmp_o};
        lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        cnt_d  = cnt_q + 8'd1;
        // The final pattern is absorbed on this edge; results freeze after it.
        if (cnt_q == LAST_CNT) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (sig_d == GOLDEN);
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        pass_d  = 1'b0;
      end
    endcase
  end

  // State registers with synchronous reset that also aborts a run.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      lfsr_q  <= SEED;
      sig_q   <= 16'h0000;
      ones_q  <= 8'h00;
      cnt_q   <= 8'h00;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      sig_q   <= sig_d;
      ones_q  <= ones_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign signature  = sig_q;
  assign ones_count = ones_q;
  assign pat_a      = lfsr_q[7:4];
  assign pat_b      = lfsr_q[3:0];
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_cmpgt_bist.sv
// Bench for cmpgt_bist: a full-length instance (fault grading) and a
// 5-pattern instance, checked against a behavioural reference model.
`timescale 1ns/1ps
module tb_cmpgt_bist;

  localparam int NPAT_L = 255;
  localparam int NPAT_S = 5;

  // ---------------- reference model ----------------
  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

  function automatic logic ref_o(input logic [7:0] p, input logic [1:0] inj);
    logic o;
    o = (p[7:4] > p[3:0]);
    if (inj == 2'b01) o = 1'b0;
    if (inj == 2'b10) o = 1'b1;
    return o;
  endfunction

  // Returns {signature, ones, final lfsr} for a run with per-pattern inject codes.
  function automatic logic [31:0] model_run(input int npat, input logic [7:0] seed,
                                            input logic [509:0] inj_vec);
    logic [15:0] sig;
    logic [7:0]  ones;
    logic [7:0]  p;
    logic        o;
    sig  = 16'h0000;
    ones = 8'h00;
    p    = seed;
    for (int k = 0; k < npat; k++) begin
      o    = ref_o(p, inj_vec[2*k +: 2]);
      sig  = {sig[14:0], sig[15] ^ sig[13] ^ sig[12] ^ sig[10] ^ o};
      ones = ones + {7'b0, o};
      p    = lfsr_next(p);
    end
    return {sig, ones, p};
  endfunction

  localparam logic [31:0] GOLD_RES = model_run(NPAT_L, 8'h01, '0);
  localparam logic [15:0] GOLD     = GOLD_RES[31:16];

  // ---------------- clock / reset / DUTs ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic        start_l, start_s;
  logic [1:0]  inject_l, inject_s;
  logic        busy_l, done_l, pass_l, cmp_l;
  logic        busy_s, done_s, pass_s, cmp_s;
  logic [15:0] sig_l, sig_s;
  logic [7:0]  ones_l, ones_s;
  logic [3:0]  pa_l, pb_l, pa_s, pb_s;
  logic [1:0]  st_l, st_s;

  always #5 clk = ~clk;

  cmpgt_bist #(.NPAT(NPAT_L), .SEED(8'h01), .GOLDEN(GOLD)) dut_l (
    .clk(clk), .rst(rst), .start(start_l), .inject_sa(inject_l),
    .busy(busy_l), .done(done_l), .pass(pass_l), .signature(sig_l),
    .ones_count(ones_l), .pat_a(pa_l), .pat_b(pb_l), .cmp_o(cmp_l),
    .state_dbg(st_l)
  );

  cmpgt_bist #(.NPAT(NPAT_S), .SEED(8'h01), .GOLDEN(16'h0000)) dut_s (
    .clk(clk), .rst(rst), .start(start_s), .inject_sa(inject_s),
    .busy(busy_s), .done(done_s), .pass(pass_s), .signature(sig_s),
    .ones_count(ones_s), .pat_a(pa_s), .pat_b(pb_s), .cmp_o(cmp_s),
    .state_dbg(st_s)
  );

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [32:0] exp_q_l[$];   // {pass, sig, ones, lfsr} per run
  logic [32:0] exp_q_s[$];
  logic [8:0]  pat_q_l[$];   // {pattern, cmp_o} per absorbed cycle
  logic [8:0]  pat_q_s[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- drivers ----------------
  // Called just after a negedge; returns just after the negedge where done shows.
  task automatic do_run_l(input logic [1:0] fixed_inj, input bit rand_inj,
                          input bit noise, input bit hold);
    logic [509:0] iv;
    logic [31:0]  r;
    logic [7:0]   p;
    iv = '0;
    for (int k = 0; k < NPAT_L; k++)
      iv[2*k +: 2] = rand_inj ? 2'($urandom_range(0, 3)) : fixed_inj;
    r = model_run(NPAT_L, 8'h01, iv);
    exp_q_l.push_back({(r[31:16] == GOLD), r});
    p = 8'h01;
    for (int k = 0; k < NPAT_L; k++) begin
      pat_q_l.push_back({p, ref_o(p, iv[2*k +: 2])});
      p = lfsr_next(p);
    end
    start_l = 1'b1;
    @(posedge clk);
    for (int k = 0; k < NPAT_L; k++) begin
      @(negedge clk);
      if (k == 0) begin
        check("run_start_busy", 32'(busy_l), 32'd1);
        check("run_start_done", 32'(done_l), 32'd0);
      end
      start_l  = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      inject_l = iv[2*k +: 2];
    end
    @(negedge clk);
    start_l = hold;
  endtask

  task automatic do_run_s();
    logic [31:0] r;
    logic [7:0]  p;
    r = model_run(NPAT_S, 8'h01, '0);
    exp_q_s.push_back({(r[31:16] == 16'h0000), r});
    p = 8'h01;
    for (int k = 0; k < NPAT_S; k++) begin
      pat_q_s.push_back({p, ref_o(p, 2'b00)});
      p = lfsr_next(p);
    end
    start_s = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_s = 1'b0;
    repeat (NPAT_S) @(negedge clk);
  endtask

  // ---------------- monitors ----------------
  initial begin
    int bc;
    logic dprev;
    logic [32:0] e;
    logic [8:0]  pe;
    bc = 0;
    dprev = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (busy_l) begin
        bc++;
        if (pat_q_l.size() > 0) begin
          pe = pat_q_l.pop_front();
          check("l_pattern", 32'({pa_l, pb_l}), 32'(pe[8:1]));
          check("l_cmp_o", 32'(cmp_l), 32'(pe[0]));
        end
      end
      if (!busy_l && !done_l) bc = 0;
      if (!done_l) check("l_pass_low", 32'(pass_l), 32'd0);
      if (done_l && !dprev) begin
        if (exp_q_l.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL l_done_unexpected: got done=1, expected no run");
        end else begin
          e = exp_q_l.pop_front();
          check("l_signature", 32'(sig_l), 32'(e[31:16]));
          check("l_ones", 32'(ones_l), 32'(e[15:8]));
          check("l_lfsr_end", 32'({pa_l, pb_l}), 32'(e[7:0]));
          check("l_pass", 32'(pass_l), 32'(e[32]));
          check("l_latency", 32'(bc), 32'(NPAT_L));
        end
        bc = 0;
      end
      dprev = done_l;
    end
  end

  initial begin
    int bc;
    logic dprev;
    logic [32:0] e;
    logic [8:0]  pe;
    bc = 0;
    dprev = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (busy_s) begin
        bc++;
        if (pat_q_s.size() > 0) begin
          pe = pat_q_s.pop_front();
          check("s_pattern", 32'({pa_s, pb_s}), 32'(pe[8:1]));
          check("s_cmp_o", 32'(cmp_s), 32'(pe[0]));
        end
      end
      if (!busy_s && !done_s) bc = 0;
      if (!done_s) check("s_pass_low", 32'(pass_s), 32'd0);
      if (done_s && !dprev) begin
        if (exp_q_s.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL s_done_unexpected: got done=1, expected no run");
        end else begin
          e = exp_q_s.pop_front();
          check("s_signature", 32'(sig_s), 32'(e[31:16]));
          check("s_ones", 32'(ones_s), 32'(e[15:8]));
          check("s_lfsr_end", 32'({pa_s, pb_s}), 32'(e[7:0]));
          check("s_pass", 32'(pass_s), 32'(e[32]));
          check("s_latency", 32'(bc), 32'(NPAT_S));
        end
        bc = 0;
      end
      dprev = done_s;
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #400000;
    $display("FAIL watchdog: got timeout, expected test end");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "timeout");
  end

  // ---------------- main sequence ----------------
  initial begin
    rst      = 1'b1;
    start_l  = 1'b0;
    start_s  = 1'b0;
    inject_l = 2'b00;
    inject_s = 2'b00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(busy_l), 32'd0);
    check("rst_done", 32'(done_l), 32'd0);
    check("rst_sig", 32'(sig_l), 32'd0);
    check("rst_ones", 32'(ones_l), 32'd0);
    check("rst_pat", 32'({pa_l, pb_l}), 32'h01);
    check("rst_state", 32'(st_l), 32'd0);
    check("rst_pat_s", 32'({pa_s, pb_s}), 32'h01);
    rst = 1'b0;
    @(negedge clk);

    // Fault-free full run.
    do_run_l(2'b00, 1'b0, 1'b0, 1'b0);
    check("full_ones_120", 32'(ones_l), 32'd120);
    check("full_lfsr_home", 32'({pa_l, pb_l}), 32'h01);
    check("full_pass", 32'(pass_l), 32'd1);
    repeat (4) @(negedge clk);
    check("done_hold", 32'(done_l), 32'd1);

    // Stuck-at-1 and stuck-at-0.
    do_run_l(2'b10, 1'b0, 1'b0, 1'b0);
    check("sa1_ones", 32'(ones_l), 32'd255);
    check("sa1_pass", 32'(pass_l), 32'd0);
    do_run_l(2'b01, 1'b0, 1'b0, 1'b0);
    check("sa0_ones", 32'(ones_l), 32'd0);
    check("sa0_sig", 32'(sig_l), 32'd0);
    check("sa0_pass", 32'(pass_l), 32'd0);

    // Code 11 behaves as no fault; random mid-run inject changes.
    do_run_l(2'b11, 1'b0, 1'b0, 1'b0);
    do_run_l(2'b00, 1'b1, 1'b0, 1'b0);
    do_run_l(2'b00, 1'b1, 1'b0, 1'b0);

    // Spurious start pulses during RUN.
    do_run_l(2'b00, 1'b0, 1'b1, 1'b0);

    // Reset in the middle of a run.
    start_l = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_l = 1'b0;
    repeat (99) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("abort_busy", 32'(busy_l), 32'd0);
    check("abort_done", 32'(done_l), 32'd0);
    check("abort_pass", 32'(pass_l), 32'd0);
    check("abort_sig", 32'(sig_l), 32'd0);
    check("abort_ones", 32'(ones_l), 32'd0);
    check("abort_pat", 32'({pa_l, pb_l}), 32'h01);
    check("abort_state", 32'(st_l), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    do_run_l(2'b00, 1'b0, 1'b0, 1'b0);
    check("rerun_sig", 32'(sig_l), 32'(GOLD));
    check("rerun_ones", 32'(ones_l), 32'd120);

    // Start held high: one DONE cycle then restart.
    do_run_l(2'b00, 1'b0, 1'b0, 1'b1);
    do_run_l(2'b00, 1'b1, 1'b0, 1'b0);

    // Short run, then restart from DONE.
    do_run_s();
    check("short_sig", 32'(sig_s), 32'd0);
    check("short_ones", 32'(ones_s), 32'd0);
    do_run_s();

    repeat (3) @(negedge clk);
    #2;
    check("l_runs_all_done", 32'(exp_q_l.size()), 32'd0);
    check("s_runs_all_done", 32'(exp_q_s.size()), 32'd0);
    check("l_patterns_all_seen", 32'(pat_q_l.size()), 32'd0);
    check("s_patterns_all_seen", 32'(pat_q_s.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cmpgt_bist.md
# cmpgt_bist

Built-in self-test wrapper for the 4-bit unsigned greater-than comparator used in the fault-simulation flow. It generates the stimulus on-chip with an 8-bit maximal LFSR and applies it to an embedded gate-level `a > b` comparator. The comparator response is compacted into a 16-bit serial signature and a ones count. It is the on-chip counterpart of the file-driven pattern generator: it produces and consumes patterns in hardware, so a fault list can be graded by signature instead of by pattern files.

## Interface
- `NPAT`, 255: number of patterns per run, 1..255.
- `SEED`, 8'h01: LFSR load value. Must be nonzero.
- `GOLDEN`, 16'h0000: expected signature, used for `pass`.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  begin a run. Sampled in IDLE and DONE, ignored in RUN.
- `inject_sa`  in  2  fault injection on comparator output `o`:
  - 00: none.
  - 01: stuck-at-0.
  - 10: stuck-at-1.
  - 11: treated as 00.
- `busy`  out  1  high in RUN.
- `done`  out  1  high in DONE.
- `pass`  out  1  `done && (signature == GOLDEN)`.
- `signature`  out  16  SISR contents.
- `ones_count`  out  8  number of absorbed patterns with `o`=1.
- `pat_a`, `pat_b`  out  4 each  current pattern, `{pat_a, pat_b} = lfsr`.
- `cmp_o`  out  1  comparator output after fault injection.

## Operation
- Comparator: structural gate netlist in the same style as the existing comparator.
  - Per bit: GT = a & ~b; LT = ~a & b; EQ = ~(GT | LT).
  - MSB-first ripple of EQ-chain and GT terms to form `o`.
  - Purely combinational on `lfsr`.
- LFSR, 8 bits, Fibonacci, polynomial x^8+x^6+x^5+x^4+1.
  - Next state = `{lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]}`, period 255.
  - From 8'h01 the sequence is 01, 02, 04, 08, 11, 23, 47, 8E, 1C, …
- SISR, 16 bits, polynomial x^16+x^14+x^13+x^11+1.
  - Next = `{sig[14:0], sig[15]^sig[13]^sig[12]^sig[10]^cmp_o}`.
- Pattern counter: 8 bits, counts patterns absorbed in the current run.
- FSM states and transitions:
  - IDLE: on `start`, load lfsr=SEED, sig=0, ones_count=0, counter=0; go to RUN.
  - RUN: each cycle absorb `cmp_o` into the SISR, add `cmp_o` to ones_count, advance the LFSR, increment the counter.
    - On the cycle absorbing pattern NPAT, go to DONE.
    - The LFSR still advances on that cycle.
  - DONE: hold all results.
    - `start` reloads exactly as from IDLE and returns to RUN.
    - Otherwise stay in DONE indefinitely.
- `start` held high continuously:
  - Only the IDLE/DONE sample has effect.
  - A run is therefore followed by exactly one DONE cycle, then a restart.
- `inject_sa` is combinational on `cmp_o` and may change mid-run; each cycle uses its current value.
- ones_count cannot overflow because NPAT ≤ 255.

## Timing
- Reset values:
  - State IDLE.
  - lfsr=SEED, sig=0, ones_count=0, counter=0.
  - busy=0, done=0, pass=0.
  - `pat_a`/`pat_b` reflect SEED.
- Reset is synchronous. Asserting it mid-RUN aborts on that edge, with the same values as above and no partial DONE.
- Run timing, with `start` sampled at edge E:
  - busy=1 after E.
  - Pattern k (k=1..NPAT) is presented between edges E+k-1 and E+k and absorbed at edge E+k.
  - At edge E+NPAT: busy=0, done=1.
  - Total latency from start to done is NPAT edges.
- `pass` is valid only while `done`=1, and is 0 otherwise.
- `signature` and `ones_count` update every RUN edge, are frozen in DONE, and are cleared on restart.

## Test plan
- Reset then `start` pulse, NPAT=255, no fault:
  - done exactly 255 cycles after the start edge.
  - ones_count=120.
  - LFSR back at 8'h01.
- NPAT=5, SEED=8'h01:
  - `{pat_a,pat_b}` sequence is 01, 02, 04, 08, 11.
  - `cmp_o`=0 for all five.
  - ones_count=0; signature=16'h0000.
- Full run with inject_sa=10:
  - ones_count=255.
  - Signature differs from the fault-free run; with GOLDEN set to the fault-free signature, pass=0.
- Full run with inject_sa=01:
  - ones_count=0, signature=16'h0000.
  - pass=0 when GOLDEN is the fault-free value.
- `rst` asserted at cycle 100 of a run:
  - Next cycle: IDLE, busy=0, done=0, all counters 0.
  - A new `start` reproduces the fault-free results bit-exactly.
- `start` pulses during RUN are ignored, with done timing unchanged. `start` in DONE restarts: done=0 and busy=1 on the next edge.
